// File: rtl/spsram_arb_pkg.sv
// -----------------------------------------------------------------------------
// spsram_arb_pkg
// Shared definitions for the two-requester single-port SRAM arbiter:
//   - default SRAM word and address widths
//   - controller state encoding (INIT clears the SRAM, RUN serves requests)
//   - requester tag carried down the read pipeline to route responses
// No ports; imported by the interface, the arbiter and the top.
// -----------------------------------------------------------------------------
package spsram_arb_pkg;

    localparam int DEF_BW_DATA = 64;
    localparam int DEF_BW_ADDR = 6;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        TAG_REQ0 = 1'b0,
        TAG_REQ1 = 1'b1
    } tag_t;

endpackage

// File: rtl/spsram_arb_if.sv
// -----------------------------------------------------------------------------
// spsram_arb_if
// Requester-side bundle of the SRAM arbiter: two command channels
// (valid/ready handshake with write-enable, address and write data) and two
// read-response channels (one-cycle valid pulse plus data).
//   slave  modport : used by the arbiter (commands in, ready/responses out)
//   master modport : used by whoever issues commands
// -----------------------------------------------------------------------------
interface spsram_arb_if
    import spsram_arb_pkg::*;
#(
    parameter int BW_DATA = DEF_BW_DATA,
    parameter int BW_ADDR = DEF_BW_ADDR
) ();

    logic               i_req0_valid;
    logic               i_req0_wen;
    logic [BW_ADDR-1:0] i_req0_addr;
    logic [BW_DATA-1:0] i_req0_data;
    logic               o_req0_ready;
    logic               o_rsp0_valid;
    logic [BW_DATA-1:0] o_rsp0_data;

    logic               i_req1_valid;
    logic               i_req1_wen;
    logic [BW_ADDR-1:0] i_req1_addr;
    logic [BW_DATA-1:0] i_req1_data;
    logic               o_req1_ready;
    logic               o_rsp1_valid;
    logic [BW_DATA-1:0] o_rsp1_data;

    modport slave (
        input  i_req0_valid, i_req0_wen, i_req0_addr, i_req0_data,
        input  i_req1_valid, i_req1_wen, i_req1_addr, i_req1_data,
        output o_req0_ready, o_rsp0_valid, o_rsp0_data,
        output o_req1_ready, o_rsp1_valid, o_rsp1_data
    );

    modport master (
        output i_req0_valid, i_req0_wen, i_req0_addr, i_req0_data,
        output i_req1_valid, i_req1_wen, i_req1_addr, i_req1_data,
        input  o_req0_ready, o_rsp0_valid, o_rsp0_data,
        input  o_req1_ready, o_rsp1_valid, o_rsp1_data
    );

endinterface

// File: rtl/spsram_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with an internal priority pointer.
//   i_clk, i_rst : clock, synchronous active-high reset (pointer -> 0)
//   i_enable     : arbitration allowed this cycle; grants are 0 otherwise
//   i_valid[1:0] : request vector
//   o_grant[1:0] : one-hot (or zero) grant, combinational from i_valid
// A grant is always taken by the requester, so every contested cycle is a
// handshake and the pointer moves to the loser; uncontested grants leave it.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Grant selection: a lone requester wins outright, a tie goes to the
    // requester the pointer currently favours.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Pointer update: after a contested grant the winner was r_ptr, so the
    // loser is simply the inverted pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_enable && (i_valid == 2'b11)) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule

// File: rtl/spsram_arb.sv
// -----------------------------------------------------------------------------
// spsram_arb
// Arbitrates two requesters onto one single-port SRAM. After reset the whole
// SRAM is cleared (INIT, one word per cycle), then commands are served at one
// per cycle (RUN). Reads return on the owning requester's response channel a
// fixed 3 cycles after acceptance, in acceptance order.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   req_bus (slave)        : requester commands, ready, read responses
//   o_mem_cen/wen/oen      : SRAM chip/write/output enable (active-high)
//   o_mem_addr, o_mem_data : SRAM address and write data
//   i_mem_data             : SRAM read data, valid the cycle after a read
//   o_init_done            : high once the post-reset clear has finished
// -----------------------------------------------------------------------------
module spsram_arb
    import spsram_arb_pkg::*;
#(
    parameter int BW_DATA = DEF_BW_DATA,
    parameter int BW_ADDR = DEF_BW_ADDR
) (
    input  logic               i_clk,
    input  logic               i_rst,
    spsram_arb_if.slave        req_bus,
    output logic               o_mem_cen,
    output logic               o_mem_wen,
    output logic               o_mem_oen,
    output logic [BW_ADDR-1:0] o_mem_addr,
    output logic [BW_DATA-1:0] o_mem_data,
    input  logic [BW_DATA-1:0] i_mem_data,
    output logic               o_init_done
);

    state_t             r_state;
    state_t             w_stateNext;
    logic [BW_ADDR-1:0] r_initAddr;

    logic               w_live;
    logic               w_run;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_cmdWen;
    logic [BW_ADDR-1:0] w_cmdAddr;
    logic [BW_DATA-1:0] w_cmdData;

    logic               r_memCen;
    logic               r_memWen;
    logic               r_memOen;
    logic [BW_ADDR-1:0] r_memAddr;
    logic [BW_DATA-1:0] r_memData;

    logic               r_rd1Valid;
    tag_t               r_rd1Tag;
    logic               r_rd2Valid;
    tag_t               r_rd2Tag;
    logic               r_rsp0Valid;
    logic               r_rsp1Valid;
    logic [BW_DATA-1:0] r_rsp0Data;
    logic [BW_DATA-1:0] r_rsp1Data;

    // Every output is forced low while reset is asserted, so a reset that
    // lands mid-RUN cannot leak a half-finished SRAM access or response.
    assign w_live = ~i_rst;
    assign w_run  = w_live && (r_state == ST_RUN);

    rr_arb2 u_rrArb2 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_run),
        .i_valid  ({req_bus.i_req1_valid, req_bus.i_req0_valid}),
        .o_grant  (w_grant)
    );

    assign w_accept             = |w_grant;
    assign req_bus.o_req0_ready = w_grant[0];
    assign req_bus.o_req1_ready = w_grant[1];

    // Command mux: forward whichever requester holds the grant.
    always_comb begin
        w_cmdWen  = req_bus.i_req0_wen;
        w_cmdAddr = req_bus.i_req0_addr;
        w_cmdData = req_bus.i_req0_data;
        if (w_grant[1]) begin
            w_cmdWen  = req_bus.i_req1_wen;
            w_cmdAddr = req_bus.i_req1_addr;
            w_cmdData = req_bus.i_req1_data;
        end
    end

    // Next-state logic: INIT leaves only after the last address is cleared.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_INIT: if (r_initAddr == '1) w_stateNext = ST_RUN;
            ST_RUN:  w_stateNext = ST_RUN;
            default: w_stateNext = ST_INIT;
        endcase
    end

    // State register and clear-address counter; the counter only walks
    // during INIT and wraps back to 0 as RUN is entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_INIT;
            r_initAddr <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == ST_INIT) begin
                r_initAddr <= r_initAddr + BW_ADDR'(1);
            end
        end
    end

    // Registered SRAM command: what is accepted this cycle is driven to the
    // SRAM next cycle. Enables drop to 0 on idle cycles; address and data
    // simply keep their last value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_memCen  <= 1'b0;
            r_memWen  <= 1'b0;
            r_memOen  <= 1'b0;
            r_memAddr <= '0;
            r_memData <= '0;
        end else begin
            r_memCen <= w_accept;
            r_memWen <= w_accept & w_cmdWen;
            r_memOen <= w_accept & ~w_cmdWen;
            if (w_accept) begin
                r_memAddr <= w_cmdAddr;
                r_memData <= w_cmdData;
            end
        end
    end

    // Read tag pipeline: stage 1 lines up with the SRAM access, stage 2 with
    // the cycle the SRAM returns data, and the response registers capture
    // that data so the pulse appears 3 cycles after acceptance. Only one
    // command enters per cycle, so responses leave in acceptance order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd1Valid  <= 1'b0;
            r_rd1Tag    <= TAG_REQ0;
            r_rd2Valid  <= 1'b0;
            r_rd2Tag    <= TAG_REQ0;
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            r_rsp0Data  <= '0;
            r_rsp1Data  <= '0;
        end else begin
            r_rd1Valid  <= w_accept & ~w_cmdWen;
            r_rd1Tag    <= w_grant[1] ? TAG_REQ1 : TAG_REQ0;
            r_rd2Valid  <= r_rd1Valid;
            r_rd2Tag    <= r_rd1Tag;
            r_rsp0Valid <= r_rd2Valid && (r_rd2Tag == TAG_REQ0);
            r_rsp1Valid <= r_rd2Valid && (r_rd2Tag == TAG_REQ1);
            if (r_rd2Valid && (r_rd2Tag == TAG_REQ0)) begin
                r_rsp0Data <= i_mem_data;
            end
            if (r_rd2Valid && (r_rd2Tag == TAG_REQ1)) begin
                r_rsp1Data <= i_mem_data;
            end
        end
    end

    // SRAM pin drive: INIT writes zero to the counter address every cycle,
    // RUN replays the registered command.
    always_comb begin
        o_mem_cen  = 1'b0;
        o_mem_wen  = 1'b0;
        o_mem_oen  = 1'b0;
        o_mem_addr = '0;
        o_mem_data = '0;
        if (w_live) begin
            if (r_state == ST_INIT) begin
                o_mem_cen  = 1'b1;
                o_mem_wen  = 1'b1;
                o_mem_addr = r_initAddr;
            end else begin
                o_mem_cen  = r_memCen;
                o_mem_wen  = r_memWen;
                o_mem_oen  = r_memOen;
                o_mem_addr = r_memAddr;
                o_mem_data = r_memData;
            end
        end
    end

    assign req_bus.o_rsp0_valid = w_live & r_rsp0Valid;
    assign req_bus.o_rsp1_valid = w_live & r_rsp1Valid;
    assign req_bus.o_rsp0_data  = w_live ? r_rsp0Data : '0;
    assign req_bus.o_rsp1_data  = w_live ? r_rsp1Data : '0;
    assign o_init_done          = w_run;

endmodule

// File: tb/tb_spsram_arb.sv
// -----------------------------------------------------------------------------
// tb_spsram_arb
// Directed bench for spsram_arb with a behavioural SRAM. Expected read data
// and response cycle are queued when a read is accepted; a separate monitor
// pops and compares whenever a response pulse appears.
// -----------------------------------------------------------------------------
module tb_spsram_arb;
    import spsram_arb_pkg::*;

    localparam int BW_DATA = 64;
    localparam int BW_ADDR = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_cen;
    logic               mem_wen;
    logic               mem_oen;
    logic [BW_ADDR-1:0] mem_addr;
    logic [BW_DATA-1:0] mem_wdata;
    logic [BW_DATA-1:0] memQ = '0;
    logic               initDone;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit                 tag;
        logic [BW_DATA-1:0] data;
        int                 cyc;
    } exp_t;

    exp_t sbq[$];

    logic [1:0] ptrPat  [4] = '{2'b11, 2'b01, 2'b11, 2'b11};
    logic [1:0] ptrExpG [4] = '{2'b01, 2'b01, 2'b10, 2'b01};

    spsram_arb_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bus ();

    spsram_arb #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .req_bus     (bus),
        .o_mem_cen   (mem_cen),
        .o_mem_wen   (mem_wen),
        .o_mem_oen   (mem_oen),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_wdata),
        .i_mem_data  (memQ),
        .o_init_done (initDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM, pre-filled with non-zero garbage so the clear is visible.
    logic [BW_DATA-1:0] mem [64];
    bit memPrimed = 1'b0;
    always @(posedge clk) begin
        if (!memPrimed) begin
            for (int i = 0; i < 64; i++) mem[i] <= 64'hDEAD_BEEF_0000_0000 + 64'(i);
            memPrimed <= 1'b1;
        end else begin
            if (mem_cen && mem_wen) mem[mem_addr] <= mem_wdata;
            if (mem_cen && mem_oen) memQ <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one command on a port and wait (bounded) for its handshake.
    task automatic applyStimulus(input bit port, input bit wen, input logic [BW_ADDR-1:0] addr,
                                 input logic [BW_DATA-1:0] data, input logic [BW_DATA-1:0] expRd);
        bit accepted = 1'b0;
        if (port) begin
            bus.i_req1_valid = 1'b1; bus.i_req1_wen = wen; bus.i_req1_addr = addr; bus.i_req1_data = data;
        end else begin
            bus.i_req0_valid = 1'b1; bus.i_req0_wen = wen; bus.i_req0_addr = addr; bus.i_req0_data = data;
        end
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            if (port ? bus.o_req1_ready : bus.o_req0_ready) begin
                accepted = 1'b1;
                if (!wen) sbq.push_back('{tag: port, data: expRd, cyc: cyc + 3});
            end
            @(posedge clk); #1;
        end
        checkOutput("accept_timeout", 64'(accepted), 64'd1);
        if (port) bus.i_req1_valid = 1'b0;
        else      bus.i_req0_valid = 1'b0;
    endtask

    // Called in the first INIT cycle; returns at the first RUN cycle's negedge.
    task automatic waitInit(input string tagName);
        int  initCycles = 0;
        int  badDrive   = 0;
        int  earlyReady = 0;
        bit  done       = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (initDone) begin
                done = 1'b1;
            end else begin
                if (!(mem_cen && mem_wen && !mem_oen && mem_addr == 6'(initCycles) && mem_wdata == '0))
                    badDrive++;
                if (bus.o_req0_ready || bus.o_req1_ready) earlyReady++;
                initCycles++;
                @(posedge clk); #1;
            end
        end
        checkOutput({tagName, "_init_cycles"}, 64'(initCycles), 64'd64);
        checkOutput({tagName, "_init_drive"}, 64'(badDrive), 64'd0);
        checkOutput({tagName, "_init_ready"}, 64'(earlyReady), 64'd0);
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    logic [BW_DATA-1:0] last0 = '0;
    logic [BW_DATA-1:0] last1 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last0 = '0;
            last1 = '0;
        end else begin
            if (bus.o_rsp0_valid || bus.o_rsp1_valid) begin
                checkOutput("rsp_onehot", 64'(bus.o_rsp0_valid & bus.o_rsp1_valid), 64'd0);
                if (sbq.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'({bus.o_rsp1_valid, bus.o_rsp0_valid}), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rsp_tag", 64'(bus.o_rsp1_valid), 64'(e.tag));
                    checkOutput("rsp_data", bus.o_rsp1_valid ? bus.o_rsp1_data : bus.o_rsp0_data, e.data);
                    checkOutput("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (bus.o_rsp0_valid) last0 = bus.o_rsp0_data;
            else checkOutput("rsp0_hold", bus.o_rsp0_data, last0);
            if (bus.o_rsp1_valid) last1 = bus.o_rsp1_data;
            else checkOutput("rsp1_hold", bus.o_rsp1_data, last1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  g0;
        int  g1;
        bit  acc0;
        bit  acc1;

        bus.i_req0_valid = 1'b0; bus.i_req0_wen = 1'b0; bus.i_req0_addr = '0; bus.i_req0_data = '0;
        bus.i_req1_valid = 1'b0; bus.i_req1_wen = 1'b0; bus.i_req1_addr = '0; bus.i_req1_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] boot: reset, clear and a read pending through INIT");
        bus.i_req0_valid = 1'b1; bus.i_req0_wen = 1'b0; bus.i_req0_addr = 6'd0;
        @(negedge clk);
        checkOutput("rst_mem_cen", 64'(mem_cen), 64'd0);
        checkOutput("rst_init_done", 64'(initDone), 64'd0);
        checkOutput("rst_ready0", 64'(bus.o_req0_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        waitInit("boot");
        checkOutput("run_first_ready0", 64'(bus.o_req0_ready), 64'd1);
        if (bus.o_req0_ready) sbq.push_back('{tag: 1'b0, data: 64'd0, cyc: cyc + 3});
        @(posedge clk); #1;
        bus.i_req0_valid = 1'b0;
        @(negedge clk);
        checkOutput("mem_read_cmd", 64'({mem_cen, mem_wen, mem_oen, mem_addr}), 64'({3'b101, 6'd0}));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("mem_idle", 64'({mem_cen, mem_wen, mem_oen}), 64'd0);
        @(posedge clk); #1;

        $display("[TB] cleared reads and write/read traffic");
        applyStimulus(1'b0, 1'b0, 6'd31, '0, 64'd0);
        applyStimulus(1'b1, 1'b0, 6'd63, '0, 64'd0);
        applyStimulus(1'b0, 1'b1, 6'd5, 64'hA5, '0);
        @(negedge clk);
        checkOutput("mem_write_cmd", 64'({mem_cen, mem_wen, mem_oen, mem_addr}), 64'({3'b110, 6'd5}));
        checkOutput("mem_write_data", mem_wdata, 64'hA5);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 6'd5, '0, 64'hA5);
        applyStimulus(1'b1, 1'b1, 6'd9, 64'h1234_5678_9ABC_DEF0, '0);
        applyStimulus(1'b1, 1'b0, 6'd9, '0, 64'h1234_5678_9ABC_DEF0);
        applyStimulus(1'b0, 1'b1, 6'd7, 64'h7777, '0);
        applyStimulus(1'b1, 1'b1, 6'd8, 64'h8888, '0);
        applyStimulus(1'b1, 1'b0, 6'd7, '0, 64'h7777);
        applyStimulus(1'b0, 1'b0, 6'd8, '0, 64'h8888);

        $display("[TB] contention: both requesters valid for 8 cycles");
        g0 = 0; g1 = 0;
        bus.i_req0_valid = 1'b1; bus.i_req0_wen = 1'b1; bus.i_req0_addr = 6'd16; bus.i_req0_data = 64'd100;
        bus.i_req1_valid = 1'b1; bus.i_req1_wen = 1'b1; bus.i_req1_addr = 6'd24; bus.i_req1_data = 64'd200;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("arb_grant", 64'({bus.o_req1_ready, bus.o_req0_ready}), (k % 2 == 0) ? 64'd1 : 64'd2);
            acc0 = bus.o_req0_ready;
            acc1 = bus.o_req1_ready;
            @(posedge clk); #1;
            if (acc0) begin g0++; bus.i_req0_addr = 6'(16 + g0); bus.i_req0_data = 64'(100 + g0); end
            if (acc1) begin g1++; bus.i_req1_addr = 6'(24 + g1); bus.i_req1_data = 64'(200 + g1); end
        end
        bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
        checkOutput("arb_count0", 64'(g0), 64'd4);
        checkOutput("arb_count1", 64'(g1), 64'd4);
        applyStimulus(1'b1, 1'b0, 6'd19, '0, 64'd103);
        applyStimulus(1'b0, 1'b0, 6'd27, '0, 64'd203);

        $display("[TB] pointer holds across an uncontested grant");
        bus.i_req0_wen = 1'b1; bus.i_req0_addr = 6'd40; bus.i_req0_data = 64'd1;
        bus.i_req1_wen = 1'b1; bus.i_req1_addr = 6'd41; bus.i_req1_data = 64'd2;
        for (int k = 0; k < 4; k++) begin
            bus.i_req0_valid = ptrPat[k][0];
            bus.i_req1_valid = ptrPat[k][1];
            @(negedge clk);
            checkOutput("ptr_grant", 64'({bus.o_req1_ready, bus.o_req0_ready}), 64'(ptrExpG[k]));
            @(posedge clk); #1;
        end
        bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;

        $display("[TB] reset right after a read accept");
        bus.i_req0_valid = 1'b1; bus.i_req0_wen = 1'b0; bus.i_req0_addr = 6'd5;
        @(negedge clk);
        checkOutput("rstrd_ready", 64'(bus.o_req0_ready), 64'd1);
        @(posedge clk); #1;
        bus.i_req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstrd_mem_cen", 64'(mem_cen), 64'd0);
        checkOutput("rstrd_init_done", 64'(initDone), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        waitInit("rerun");
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 6'd5, '0, 64'd0);
        applyStimulus(1'b1, 1'b0, 6'd9, '0, 64'd0);

        repeat (6) @(posedge clk);
        #1;
        checkOutput("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
